// File: rtl/ex_stage.sv
// Purpose : execute stage - ALU, Z/N flags, branch/jump resolution, EX/MEM register.
// Latency : 1 cycle from ID/EX inputs to EX/MEM outputs; redirect is combinational.
// Backpr. : stall holds EX/MEM and flags and masks redirect; flush loads a bubble.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_in, stall, flush   pipeline control
//   rs, rt, addr, rd, alu_op operands, immediate/PC value, destination, ALU op
//   reg_write .. jump_mem    decoded control bits
//   redirect, redirect_target  fetch redirect (target = rs)
//   flag_z, flag_n           registered condition flags
//   valid_out .. jump_mem_out  EX/MEM register contents
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [DATA_W-1:0] addr,
  input  logic [RD_W-1:0]   rd,
  input  logic [OP_W-1:0]   alu_op,
  input  logic              reg_write,
  input  logic              branch_z,
  input  logic              branch_neg,
  input  logic              memtoreg,
  input  logic              pctoreg,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic              jump,
  input  logic              jump_mem,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_target,
  output logic              flag_z,
  output logic              flag_n,
  output logic              valid_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [DATA_W-1:0] mem_addr_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              reg_write_out,
  output logic              memtoreg_out,
  output logic              mem_r_out,
  output logic              mem_w_out,
  output logic              jump_mem_out
);

  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_result;
  logic              w_flag_upd;

  logic              r_flag_z, r_flag_n;
  logic              r_valid;
  logic [DATA_W-1:0] r_result, r_store_data, r_mem_addr;
  logic [RD_W-1:0]   r_rd;
  logic              r_reg_write, r_memtoreg, r_mem_r, r_mem_w, r_jump_mem;

  always_comb begin
    w_alu = '0;
    case (alu_op)
      OP_W'(0): w_alu = rs + rt;
      OP_W'(1): w_alu = rs - rt;
      OP_W'(2): w_alu = '0 - rs;
      OP_W'(3): w_alu = rs + addr;
      OP_W'(4): w_alu = rs;
      OP_W'(5): w_alu = rt;
      OP_W'(6): w_alu = rs & rt;
      OP_W'(7): w_alu = rs | rt;
      default:  w_alu = '0;
    endcase
  end

  assign w_result = pctoreg ? addr : w_alu;

  // Only ALU instructions that write a register touch the flags; loads,
  // svpc, stores, branches and bubbles leave them alone.
  assign w_flag_upd = valid_in & reg_write & ~memtoreg & ~pctoreg;

  // Branches look at the registered flags, i.e. the last completed ALU op.
  // Masking with stall makes a held branch redirect only once, when it moves.
  assign redirect = valid_in & ~flush & ~stall & ~rst &
                    ((branch_z & r_flag_z) | (branch_neg & r_flag_n) | jump);
  assign redirect_target = rs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_z     <= 1'b0;
      r_flag_n     <= 1'b0;
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_mem_addr   <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_mem_r      <= 1'b0;
      r_mem_w      <= 1'b0;
      r_jump_mem   <= 1'b0;
    end else if (flush) begin
      // Bubble: flags hold, everything in EX/MEM cleared.
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_mem_addr   <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_mem_r      <= 1'b0;
      r_mem_w      <= 1'b0;
      r_jump_mem   <= 1'b0;
    end else if (!stall) begin
      r_valid      <= valid_in;
      r_result     <= w_result;
      r_store_data <= rt;
      r_mem_addr   <= rs;
      r_rd         <= rd;
      r_reg_write  <= valid_in & reg_write;
      r_memtoreg   <= valid_in & memtoreg;
      r_mem_r      <= valid_in & mem_r;
      r_mem_w      <= valid_in & mem_w;
      r_jump_mem   <= valid_in & jump_mem;
      if (w_flag_upd) begin
        r_flag_z <= (w_alu == '0);
        r_flag_n <= w_alu[DATA_W-1];
      end
    end
  end

  assign flag_z         = r_flag_z;
  assign flag_n         = r_flag_n;
  assign valid_out      = r_valid;
  assign result_out     = r_result;
  assign store_data_out = r_store_data;
  assign mem_addr_out   = r_mem_addr;
  assign rd_out         = r_rd;
  assign reg_write_out  = r_reg_write;
  assign memtoreg_out   = r_memtoreg;
  assign mem_r_out      = r_mem_r;
  assign mem_w_out      = r_mem_w;
  assign jump_mem_out   = r_jump_mem;

endmodule

// File: tb/tb_ex_stage.sv
// Purpose : directed self-checking bench for ex_stage.
// Latency : checks registered outputs 1 ns after the edge, redirect before the edge.
// Backpr. : exercises stall, flush and stall+flush.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, valid_in, stall, flush;
  logic [31:0] rs, rt, addr;
  logic [5:0]  rd;
  logic [3:0]  alu_op;
  logic        reg_write, branch_z, branch_neg, memtoreg, pctoreg;
  logic        mem_r, mem_w, jump, jump_mem;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        flag_z, flag_n, valid_out;
  logic [31:0] result_out, store_data_out, mem_addr_out;
  logic [5:0]  rd_out;
  logic        reg_write_out, memtoreg_out, mem_r_out, mem_w_out, jump_mem_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(32), .RD_W(6), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
    .rs(rs), .rt(rt), .addr(addr), .rd(rd), .alu_op(alu_op),
    .reg_write(reg_write), .branch_z(branch_z), .branch_neg(branch_neg),
    .memtoreg(memtoreg), .pctoreg(pctoreg), .mem_r(mem_r), .mem_w(mem_w),
    .jump(jump), .jump_mem(jump_mem),
    .redirect(redirect), .redirect_target(redirect_target),
    .flag_z(flag_z), .flag_n(flag_n), .valid_out(valid_out),
    .result_out(result_out), .store_data_out(store_data_out),
    .mem_addr_out(mem_addr_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .memtoreg_out(memtoreg_out),
    .mem_r_out(mem_r_out), .mem_w_out(mem_w_out), .jump_mem_out(jump_mem_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    valid_in = 0; stall = 0; flush = 0;
    rs = 0; rt = 0; addr = 0; rd = 0; alu_op = 0;
    reg_write = 0; branch_z = 0; branch_neg = 0; memtoreg = 0; pctoreg = 0;
    mem_r = 0; mem_w = 0; jump = 0; jump_mem = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic wr);
    clr();
    valid_in = 1; alu_op = op; rs = a; rt = b; reg_write = wr;
  endtask

  initial begin
    clr();
    rst = 1;
    tick(); tick();
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    chk("rst_store", store_data_out, 32'd0);
    chk("rst_maddr", mem_addr_out, 32'd0);
    chk("rst_rd", {26'b0, rd_out}, 32'd0);
    chk("rst_ctl", {27'b0, reg_write_out, memtoreg_out, mem_r_out, mem_w_out, jump_mem_out}, 32'd0);
    chk("rst_flags", {30'b0, flag_z, flag_n}, 32'd0);
    rst = 0;

    // ADD 5+7 -> 12
    alu(4'd0, 32'd5, 32'd7, 1'b1); rd = 6'd3;
    tick();
    chk("add_result", result_out, 32'd12);
    chk("add_rd", {26'b0, rd_out}, 32'd3);
    chk("add_rw_vld", {30'b0, reg_write_out, valid_out}, 32'd3);
    chk("add_flags", {30'b0, flag_z, flag_n}, 32'd0);
    chk("add_store", store_data_out, 32'd7);
    chk("add_maddr", mem_addr_out, 32'd5);

    // SUB 9-9 -> Z
    alu(4'd1, 32'd9, 32'd9, 1'b1);
    tick();
    chk("sub_result", result_out, 32'd0);
    chk("sub_flags", {30'b0, flag_z, flag_n}, 32'd2);

    // brz taken
    clr(); valid_in = 1; branch_z = 1; rs = 32'h40;
    #1;
    chk("brz_taken", {31'b0, redirect}, 32'd1);
    chk("brz_target", redirect_target, 32'h40);
    tick();
    chk("brz_flags_hold", {30'b0, flag_z, flag_n}, 32'd2);

    // ADD 1+1 clears Z, brz not taken
    alu(4'd0, 32'd1, 32'd1, 1'b1);
    tick();
    chk("add11_flags", {30'b0, flag_z, flag_n}, 32'd0);
    clr(); valid_in = 1; branch_z = 1; rs = 32'h40;
    #1;
    chk("brz_not_taken", {31'b0, redirect}, 32'd0);
    tick();

    // NEG 1 -> all ones, N
    alu(4'd2, 32'd1, 32'd0, 1'b1);
    tick();
    chk("neg_result", result_out, 32'hFFFF_FFFF);
    chk("neg_flags", {30'b0, flag_z, flag_n}, 32'd1);

    // ld: ALU output 0 but memtoreg blocks flag update
    alu(4'd4, 32'd0, 32'd0, 1'b1); memtoreg = 1; mem_r = 1;
    tick();
    chk("ld_flags", {30'b0, flag_z, flag_n}, 32'd1);
    chk("ld_ctl", {30'b0, memtoreg_out, mem_r_out}, 32'd3);

    // brn taken
    clr(); valid_in = 1; branch_neg = 1; rs = 32'h80;
    #1;
    chk("brn_taken", {31'b0, redirect}, 32'd1);
    chk("brn_target", redirect_target, 32'h80);
    tick();

    // ADD 2+3 without reg_write (flags keep N), then stall
    alu(4'd0, 32'd2, 32'd3, 1'b0);
    tick();
    chk("stl_load", result_out, 32'd5);
    clr(); stall = 1; valid_in = 1; branch_neg = 1; rs = 32'h80; rt = 32'h80; reg_write = 0;
    #1;
    chk("stl_redirect_masked", {31'b0, redirect}, 32'd0);
    tick(); chk("stl_hold1", result_out, 32'd5);
    tick(); chk("stl_hold2", result_out, 32'd5);
    tick(); chk("stl_hold3", result_out, 32'd5);
    chk("stl_flags", {30'b0, flag_z, flag_n}, 32'd1);
    stall = 0;
    #1;
    chk("stl_release_redirect", {31'b0, redirect}, 32'd1);
    tick();
    clr();
    #1;
    chk("stl_redirect_once", {31'b0, redirect}, 32'd0);
    chk("stl_brn_adv", {31'b0, valid_out}, 32'd1);

    // Flushed jump with ALU/control bits set
    alu(4'd0, 32'h10, 32'd0, 1'b1); jump = 1; mem_w = 1; rd = 6'd5; flush = 1;
    #1;
    chk("fl_redirect", {31'b0, redirect}, 32'd0);
    tick();
    chk("fl_valid", {31'b0, valid_out}, 32'd0);
    chk("fl_ctl", {27'b0, reg_write_out, memtoreg_out, mem_r_out, mem_w_out, jump_mem_out}, 32'd0);
    chk("fl_flags", {30'b0, flag_z, flag_n}, 32'd1);
    chk("fl_data", result_out, 32'd0);

    // Load a valid op, then flush+stall -> bubble
    alu(4'd0, 32'd1, 32'd1, 1'b1); mem_w = 1;
    tick();
    chk("fs_pre", {30'b0, valid_out, mem_w_out}, 32'd3);
    stall = 1; flush = 1;
    tick();
    chk("fs_bubble", {29'b0, valid_out, reg_write_out, mem_w_out}, 32'd0);
    chk("fs_data", result_out, 32'd0);

    // Bubble load: control bits forced to 0 when valid_in=0
    clr(); reg_write = 1; mem_r = 1; mem_w = 1; memtoreg = 1; jump_mem = 1; rs = 32'd7;
    tick();
    chk("bub_ctl", {26'b0, valid_out, reg_write_out, memtoreg_out, mem_r_out, mem_w_out, jump_mem_out}, 32'd0);

    // jump_mem forwarded, no redirect
    clr(); valid_in = 1; jump_mem = 1; rs = 32'h99;
    #1;
    chk("jm_no_redirect", {31'b0, redirect}, 32'd0);
    tick();
    chk("jm_out", {31'b0, jump_mem_out}, 32'd1);

    // Remaining ALU ops (no reg_write)
    alu(4'd3, 32'd10, 32'd0, 1'b0); addr = 32'd5;
    tick(); chk("inc", result_out, 32'd15);
    alu(4'd6, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    tick(); chk("and", result_out, 32'h0000_F000);
    alu(4'd7, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    tick(); chk("or", result_out, 32'h0000_FFF0);
    alu(4'd5, 32'h1234, 32'hABCD, 1'b0);
    tick(); chk("pass_rt", result_out, 32'hABCD);
    alu(4'd4, 32'h1234, 32'hABCD, 1'b0);
    tick(); chk("pass_rs", result_out, 32'h1234);
    alu(4'd9, 32'h1234, 32'hABCD, 1'b0);
    tick(); chk("bad_op", result_out, 32'd0);

    // Wrap to zero
    alu(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick();
    chk("wrap_result", result_out, 32'd0);
    chk("wrap_flags", {30'b0, flag_z, flag_n}, 32'd2);

    // svpc: result is addr, flags unchanged
    alu(4'd0, 32'd3, 32'd4, 1'b1); pctoreg = 1; addr = 32'h24;
    tick();
    chk("svpc_result", result_out, 32'h24);
    chk("svpc_flags", {30'b0, flag_z, flag_n}, 32'd2);

    // Reset asserted in the middle of a stall
    alu(4'd2, 32'd1, 32'd0, 1'b1); mem_w = 1;
    tick();
    chk("rs_pre_flags", {30'b0, flag_z, flag_n}, 32'd1);
    stall = 1;
    tick();
    chk("rs_stall_hold", result_out, 32'hFFFF_FFFF);
    rst = 1; jump = 1; stall = 0;
    #1;
    chk("rs_redirect", {31'b0, redirect}, 32'd0);
    stall = 1;
    tick();
    chk("rs_result", result_out, 32'd0);
    chk("rs_valid_ctl", {26'b0, valid_out, reg_write_out, memtoreg_out, mem_r_out, mem_w_out, jump_mem_out}, 32'd0);
    chk("rs_flags", {30'b0, flag_z, flag_n}, 32'd0);
    chk("rs_data", store_data_out | mem_addr_out, 32'd0);
    rst = 0;
    clr();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
